// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, colour-bar table and RGB payload type.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int unsigned BAR_N     = 8;
   localparam int unsigned BAR_W     = H_ACTIVE / BAR_N;
   localparam int unsigned BAR_IDX_W = 3;
   localparam int unsigned BAR_POS_W = 7;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned CH_W      = 4;

   typedef struct packed {
      logic [CH_W-1:0] red;
      logic [CH_W-1:0] green;
      logic [CH_W-1:0] blue;
   } rgb_t;

   // Bar colours, index 0 (white, left) .. 7 (black, right)
   localparam logic [BAR_N-1:0][3*CH_W-1:0] BAR_RGB = {
      12'h000,   // 7 black
      12'h00F,   // 6 blue
      12'hF00,   // 5 red
      12'hF0F,   // 4 magenta
      12'h0F0,   // 3 green
      12'h0FF,   // 2 cyan
      12'hFF0,   // 1 yellow
      12'hFFF    // 0 white
   };

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel/line counters with sync, active-region and colour-bar index generation.
module vga_sync_counter #(
   parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   output logic [2:0] bar,
   output logic       hsync_c,
   output logic       vsync_c,
   output logic       active_c
);
   import vga_timing_pkg::*;

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [BAR_POS_W-1:0] BAR_LAST = BAR_POS_W'(BAR_W - 1);

   logic [CNT_W-1:0]     hcnt;
   logic [CNT_W-1:0]     vcnt;
   logic [BAR_POS_W-1:0] bar_pos;

   // Advance pixel/line counters and the bar tracker on each pixel tick
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt    <= '0;
         vcnt    <= '0;
         bar_pos <= '0;
         bar     <= '0;
      end else if (tick) begin
         if (hcnt == H_LAST) begin
            hcnt    <= '0;
            bar_pos <= '0;
            bar     <= '0;
            if (vcnt == V_LAST) begin
               vcnt <= '0;
            end else begin
               vcnt <= vcnt + CNT_W'(1);
            end
         end else begin
            hcnt <= hcnt + CNT_W'(1);
            // bar index = hcnt / BAR_W, tracked by a sub-bar position counter
            if (bar_pos == BAR_LAST) begin
               bar_pos <= '0;
               bar     <= bar + 3'(1);
            end else begin
               bar_pos <= bar_pos + BAR_POS_W'(1);
            end
         end
      end
   end

   // Active-low syncs and active-region flag for the current position
   always_comb begin
      hsync_c  = ~((hcnt >= HS_START) && (hcnt <= HS_END));
      vsync_c  = ~((vcnt >= VS_START) && (vcnt <= VS_END));
      active_c = (hcnt < H_ACT) && (vcnt < V_ACT);
   end

endmodule

// File: rtl/vga_output.sv
// VGA 640x480 timing and 8-bar colour test pattern, pixel clock = OSC48M/2.
module vga_output #(
   parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
   input  logic       OSC48M,
   input  logic       RST,
   output logic       VSYNCX,
   output logic       HSYNCX,
   output logic       DCLK,
   output logic [3:0] RED,
   output logic [3:0] GREEN,
   output logic [3:0] BLUE
);
   import vga_timing_pkg::*;

   logic       tick;
   logic [2:0] bar;
   logic       hsync_c;
   logic       vsync_c;
   logic       active_c;
   rgb_t       rgb;

   // One pixel per two oscillator cycles: tick while DCLK is high, so outputs move as DCLK falls
   assign tick = DCLK;

   vga_sync_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_sync_counter (
      .clk      (OSC48M),
      .rst      (RST),
      .tick     (tick),
      .bar      (bar),
      .hsync_c  (hsync_c),
      .vsync_c  (vsync_c),
      .active_c (active_c)
   );

   // Pixel clock divider and registered sync/RGB output stage
   always_ff @(posedge OSC48M) begin
      if (RST) begin
         DCLK   <= 1'b0;
         HSYNCX <= 1'b1;
         VSYNCX <= 1'b1;
         rgb    <= '0;
      end else begin
         DCLK <= ~DCLK;
         if (tick) begin
            HSYNCX <= hsync_c;
            VSYNCX <= vsync_c;
            rgb    <= active_c ? rgb_t'(BAR_RGB[bar]) : '0;
         end
      end
   end

   assign RED   = rgb.red;
   assign GREEN = rgb.green;
   assign BLUE  = rgb.blue;

endmodule

// File: tb/tb_vga_output.sv
// Directed checks of VGA timing and colour bars; a second instance uses a short frame.
module tb_vga_output;

   logic       osc48m;
   logic       rst;
   logic       rst_b;
   logic       vsyncx, hsyncx, dclk;
   logic [3:0] red, green, blue;
   logic       vsyncx_b, hsyncx_b, dclk_b;
   logic [3:0] red_b, green_b, blue_b;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;

   vga_output dut (
      .OSC48M (osc48m),
      .RST    (rst),
      .VSYNCX (vsyncx),
      .HSYNCX (hsyncx),
      .DCLK   (dclk),
      .RED    (red),
      .GREEN  (green),
      .BLUE   (blue)
   );

   // Frame of 8 lines: active 0..2, vsync low on lines 4..5
   vga_output #(
      .V_ACTIVE (3),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (2)
   ) dut_b (
      .OSC48M (osc48m),
      .RST    (rst_b),
      .VSYNCX (vsyncx_b),
      .HSYNCX (hsyncx_b),
      .DCLK   (dclk_b),
      .RED    (red_b),
      .GREEN  (green_b),
      .BLUE   (blue_b)
   );

   initial osc48m = 1'b0;
   always #10 osc48m = ~osc48m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one oscillator edge and sample just after it
   task automatic step();
      @(posedge osc48m);
      #1;
      ecnt++;
   endtask

   task automatic goto_edge(input int e);
      while (ecnt < e) step();
   endtask

   // Edge after release at which pixel p of line l is on the outputs
   function automatic int pix_edge(input int l, input int p);
      return 2 + 2 * (800 * l + p);
   endfunction

   function automatic logic [31:0] rgb_a();
      return {20'd0, red, green, blue};
   endfunction

   function automatic logic [31:0] rgb_b();
      return {20'd0, red_b, green_b, blue_b};
   endfunction

   initial begin
      rst   = 1'b1;
      rst_b = 1'b1;
      repeat (20) step();
      chk("rst_dclk",   {31'd0, dclk},   32'd0);
      chk("rst_hsync",  {31'd0, hsyncx}, 32'd1);
      chk("rst_vsync",  {31'd0, vsyncx}, 32'd1);
      chk("rst_rgb",    rgb_a(),         32'h000);
      chk("rst_b_vsync", {31'd0, vsyncx_b}, 32'd1);

      rst   = 1'b0;
      rst_b = 1'b0;
      ecnt  = 0;

      goto_edge(1);
      chk("dclk_e1",  {31'd0, dclk}, 32'd1);
      chk("rgb_e1",   rgb_a(),       32'h000);
      goto_edge(2);
      chk("dclk_e2",  {31'd0, dclk}, 32'd0);
      chk("px0",      rgb_a(),       32'hFFF);
      goto_edge(3);
      chk("dclk_e3",  {31'd0, dclk}, 32'd1);
      chk("px0_hold", rgb_a(),       32'hFFF);
      goto_edge(4);
      chk("dclk_e4",  {31'd0, dclk}, 32'd0);

      goto_edge(pix_edge(0, 79));  chk("px79",  rgb_a(), 32'hFFF);
      goto_edge(pix_edge(0, 80));  chk("px80",  rgb_a(), 32'hFF0);
      goto_edge(pix_edge(0, 160)); chk("px160", rgb_a(), 32'h0FF);
      goto_edge(pix_edge(0, 300)); chk("px300", rgb_a(), 32'h0F0);
      goto_edge(pix_edge(0, 320)); chk("px320", rgb_a(), 32'hF0F);
      goto_edge(pix_edge(0, 400)); chk("px400", rgb_a(), 32'hF00);
      goto_edge(pix_edge(0, 480)); chk("px480", rgb_a(), 32'h00F);
      goto_edge(pix_edge(0, 560)); chk("px560", rgb_a(), 32'h000);
      goto_edge(pix_edge(0, 639)); chk("px639", rgb_a(), 32'h000);
      goto_edge(pix_edge(0, 640)); chk("px640", rgb_a(), 32'h000);

      goto_edge(pix_edge(0, 655)); chk("hs_655", {31'd0, hsyncx}, 32'd1);
      goto_edge(pix_edge(0, 656)); chk("hs_656", {31'd0, hsyncx}, 32'd0);
      chk("hs_first_edge", 32'(ecnt), 32'd1314);
      goto_edge(pix_edge(0, 751)); chk("hs_751", {31'd0, hsyncx}, 32'd0);
      goto_edge(pix_edge(0, 752)); chk("hs_752", {31'd0, hsyncx}, 32'd1);
      chk("vs_line0", {31'd0, vsyncx}, 32'd1);
      goto_edge(pix_edge(0, 799)); chk("px799", rgb_a(), 32'h000);

      goto_edge(pix_edge(1, 0));   chk("l1_px0",  rgb_a(), 32'hFFF);
      goto_edge(pix_edge(1, 85));  chk("l1_px85", rgb_a(), 32'hFF0);
      goto_edge(pix_edge(1, 655)); chk("l1_hs_655", {31'd0, hsyncx}, 32'd1);
      goto_edge(pix_edge(1, 656)); chk("l1_hs_656", {31'd0, hsyncx}, 32'd0);

      // Reset pulse mid-line on line 2, pixel 300
      goto_edge(pix_edge(2, 300)); chk("l2_px300", rgb_a(), 32'h0F0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_dclk",  {31'd0, dclk},   32'd0);
      chk("mid_rst_hsync", {31'd0, hsyncx}, 32'd1);
      chk("mid_rst_vsync", {31'd0, vsyncx}, 32'd1);
      chk("mid_rst_rgb",   rgb_a(),         32'h000);
      ecnt = 0;
      goto_edge(1);                chk("re_dclk_e1", {31'd0, dclk}, 32'd1);
      goto_edge(pix_edge(0, 0));   chk("re_px0",     rgb_a(), 32'hFFF);
      goto_edge(pix_edge(0, 80));  chk("re_px80",    rgb_a(), 32'hFF0);
      goto_edge(pix_edge(0, 655)); chk("re_hs_655",  {31'd0, hsyncx}, 32'd1);
      goto_edge(pix_edge(0, 656)); chk("re_hs_656",  {31'd0, hsyncx}, 32'd0);

      // Short-frame instance: restart it and walk through its vertical timing
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      chk("b_rst_rgb", rgb_b(), 32'h000);
      ecnt = 0;
      goto_edge(pix_edge(0, 0));   chk("b_px0",      rgb_b(), 32'hFFF);
      goto_edge(pix_edge(2, 0));   chk("b_l2_px0",   rgb_b(), 32'hFFF);
      goto_edge(pix_edge(3, 0));   chk("b_l3_blank", rgb_b(), 32'h000);
      goto_edge(pix_edge(3, 799)); chk("b_vs_l3",    {31'd0, vsyncx_b}, 32'd1);
      goto_edge(pix_edge(4, 0));   chk("b_vs_l4",    {31'd0, vsyncx_b}, 32'd0);
      goto_edge(pix_edge(5, 799)); chk("b_vs_l5",    {31'd0, vsyncx_b}, 32'd0);
      goto_edge(pix_edge(6, 0));   chk("b_vs_l6",    {31'd0, vsyncx_b}, 32'd1);
      goto_edge(pix_edge(7, 90));  chk("b_l7_blank", rgb_b(), 32'h000);
      goto_edge(pix_edge(8, 0));   chk("b_f2_px0",   rgb_b(), 32'hFFF);
      goto_edge(pix_edge(8, 90));  chk("b_f2_px90",  rgb_b(), 32'hFF0);
      goto_edge(pix_edge(11, 799)); chk("b_f2_vs_l3", {31'd0, vsyncx_b}, 32'd1);
      goto_edge(pix_edge(12, 0));  chk("b_f2_vs_l4", {31'd0, vsyncx_b}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_output.md
Name: vga_output

Overview:
- Stand-alone VGA/parallel-RGB LCD timing and test-pattern generator, driven from the board's 48 MHz oscillator.
- Divides the oscillator by 2 to produce a 24 MHz pixel clock (DCLK).
- Generates 640x480 VGA-style timing with active-low HSYNCX/VSYNCX.
- Drives a 4-bit-per-channel, 8-bar vertical colour-bar pattern. Top-level display driver; no upstream data interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525
- BAR_W, 80, colour-bar width in pixels (H_ACTIVE/8)

Ports:
- OSC48M  in  1  48 MHz system clock; all logic on its rising edge
- RST  in  1  synchronous, active-high reset
- VSYNCX  out  1  vertical sync, active low
- HSYNCX  out  1  horizontal sync, active low
- DCLK  out  1  pixel clock, OSC48M/2, 50% duty
- RED  out  4  red intensity
- GREEN  out  4  green intensity
- BLUE  out  4  blue intensity

Behaviour:
- Single clock domain, OSC48M. Reset is synchronous and active-high. Every output is driven from a register; no combinational paths to outputs.
- Reset values: DCLK=0, HSYNCX=1, VSYNCX=1, RED/GREEN/BLUE=0, hcnt=0, vcnt=0.
- DCLK register toggles every OSC48M cycle when RST=0. Internal tick = (DCLK==1).
- On each tick, with hcnt/vcnt taken before they advance:
  - Outputs update from the current (hcnt, vcnt). They change as DCLK falls and are stable at the next DCLK rising edge.
  - hcnt increments; it wraps 799->0.
  - On the hcnt wrap, vcnt increments; it wraps 524->0.
- With no tick, counters and outputs hold.
- HSYNCX=0 iff 656 <= hcnt <= 751 (H_ACTIVE+H_FP to H_ACTIVE+H_FP+H_SYNC-1); otherwise 1.
- VSYNCX=0 iff 490 <= vcnt <= 491; otherwise 1.
- Active region: hcnt<640 and vcnt<480. Outside it, RGB=0 (blanking).
- Inside the active region, bar index = hcnt/BAR_W, range 0..7, implemented with compare/counter (no divider). Bar colours as R,G,B:
  - 0 white F,F,F
  - 1 yellow F,F,0
  - 2 cyan 0,F,F
  - 3 green 0,F,0
  - 4 magenta F,0,F
  - 5 red F,0,0
  - 6 blue 0,0,F
  - 7 black 0,0,0
- Timing derived from parameters:
  - Line period: 800 DCLK = 1600 OSC48M cycles (33.33 us).
  - Frame period: 420000 DCLK = 840000 OSC48M cycles (~57.1 Hz).
- First tick after reset release is on the 2nd OSC48M edge. Pixel (0,0) (white) appears on the RGB outputs after that edge.
- Reset asserted mid-frame: on the next edge all registers return to reset values. The frame restarts at (0,0); no partial-state carry-over.
- Counter widths: hcnt 10 bits, vcnt 10 bits. Counters are unsigned with equality wrap; they never reach values above total-1.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the H/V timing constants and derived totals/sync start/end
  - a colour-bar lookup constant array (8 x 12-bit RGB)
- One natural sub-module, vga_sync_counter: hcnt/vcnt generation plus sync/active flags, with tick enable.
- The top vga_output contains the DCLK divider, that counter, and the colour-bar RGB register stage.

Test Plan:
- Reset held 20 cycles, then released -> during reset DCLK=0, HSYNCX=VSYNCX=1, RGB=000. After release DCLK period = 2 OSC48M cycles (41.67 ns), duty 50%.
- Measure HSYNCX -> falling-edge spacing 1600 OSC48M cycles, low width 192 cycles, first falling edge 656 ticks after reset (~1312 cycles + 2).
- Measure VSYNCX -> period 840000 OSC48M cycles, low width 3200 cycles (2 lines).
- Sample RGB at line 0:
  - pixel 0 -> FFF
  - pixel 79 -> FFF
  - pixel 80 -> FF0
  - pixel 400 -> F00
  - pixel 560 -> 000
  - pixel 639 -> 000
  - pixel 640..799 -> 000
  - any pixel on line 480..524 -> 000
- Assert RST for 1 cycle mid-line (e.g. hcnt=300, vcnt=100) -> next cycle all outputs at reset values. Next HSYNCX falling edge is 656 ticks after release.
